// File: rtl/adder_operand_loader.sv
// adder_operand_loader
//   Serial-to-parallel front end for the 3-stage pipelined 8-operand adder tree.
//   Operand bytes arrive one per beat on a valid/ready stream. They are packed
//   into groups of NUM_OPS, and each group is launched as stable parallel
//   operands in0..in7 with a one-cycle out_valid pulse. A PIPE_LAT-deep shift
//   register follows each launch and raises sum_valid on the cycle the tree's
//   registered sum holds that group's result.
//
//   Handshake: a byte transfers on a rising edge where s_valid and s_ready are
//   both high. s_ready depends only on FSM state, never on s_valid. The
//   producer must hold s_data/s_last stable while s_valid is high and s_ready
//   is low.
//
//   Optional feature: define ADDER_LOADER_FLUSH_EN to add the flush input.
//   flush discards the partial group and has priority over a same-edge
//   transfer or launch. It does not affect in0..in7 or pending sum_valid pulses.
module adder_operand_loader #(
  parameter int DATA_W   = 8,
  parameter int NUM_OPS  = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ADDER_LOADER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] in3,
  output logic [DATA_W-1:0] in4,
  output logic [DATA_W-1:0] in5,
  output logic [DATA_W-1:0] in6,
  output logic [DATA_W-1:0] in7,
  output logic              out_valid,
  output logic              sum_valid,
  output logic              pad_flag,
  output logic              state_dbg
);

  localparam int IDX_W = $clog2(NUM_OPS);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_OPS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   buf_q   [NUM_OPS];
  logic [DATA_W-1:0]   ops_q   [NUM_OPS];
  logic [DATA_W-1:0]   group_d [NUM_OPS];
  logic [PIPE_LAT-1:0] lat_q;
  logic                flush_i;
  logic                accept;
  logic                last_slot;
  logic                launch;

`ifdef ADDER_LOADER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // FSM state register: IDLE for one cycle out of reset, then FILL forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and s_ready decode.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: s_ready = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_dbg = (state_q == ST_FILL);

  // A flushed edge neither stores nor launches the byte on s_data.
  assign accept    = s_valid & s_ready & ~flush_i;
  assign last_slot = (idx_q == LAST_SLOT);
  assign launch    = accept & (last_slot | s_last);

  // Assemble the group being launched: earlier slots from the buffer, the
  // current byte in slot idx, zero padding after it.
  always_comb begin
    for (int k = 0; k < NUM_OPS; k++) begin
      group_d[k] = '0;
      if (IDX_W'(k) < idx_q)       group_d[k] = buf_q[k];
      else if (IDX_W'(k) == idx_q) group_d[k] = s_data;
    end
  end

  // Capture buffer and slot index: fill on accept, clear on launch or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '{default: '0};
      idx_q <= '0;
    end else if (flush_i || launch) begin
      buf_q <= '{default: '0};
      idx_q <= '0;
    end else if (accept) begin
      buf_q[idx_q] <= s_data;
      idx_q        <= idx_q + 1'b1;
    end
  end

  // Launch register: operands change only on a launch edge; pulses follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q     <= '{default: '0};
      out_valid <= 1'b0;
      pad_flag  <= 1'b0;
    end else begin
      out_valid <= launch;
      pad_flag  <= launch & ~last_slot;
      if (launch) ops_q <= group_d;
    end
  end

  // Latency tracker: each launch pulse walks PIPE_LAT taps to sum_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lat_q <= '0;
    else      lat_q <= (lat_q << 1) | PIPE_LAT'(out_valid);
  end

  assign sum_valid = lat_q[PIPE_LAT-1];

  assign in0 = ops_q[0];
  assign in1 = ops_q[1];
  assign in2 = ops_q[2];
  assign in3 = ops_q[3];
  assign in4 = ops_q[4];
  assign in5 = ops_q[5];
  assign in6 = ops_q[6];
  assign in7 = ops_q[7];

endmodule

// File: tb/tb_adder_operand_loader.sv
// Testbench for adder_operand_loader: bytes go through driver tasks, a
// background monitor records every launch and sum_valid pulse, and a
// group-level reference model builds the expected operand groups, pad flags
// and wrapped sums from the accepted byte stream.
module tb_adder_operand_loader;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_last  = 1'b0;
`ifdef ADDER_LOADER_FLUSH_EN
  logic       flush   = 1'b0;
`endif
  logic       s_ready;
  logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic       out_valid;
  logic       sum_valid;
  logic       pad_flag;
  logic       state_dbg;
  logic [63:0] ops_w;

  assign ops_w = {in7, in6, in5, in4, in3, in2, in1, in0};

  adder_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ADDER_LOADER_FLUSH_EN
    .flush     (flush),
`endif
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .in6       (in6),
    .in7       (in7),
    .out_valid (out_valid),
    .sum_valid (sum_valid),
    .pad_flag  (pad_flag),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got timeout required finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mdl_bytes[$];
  logic [63:0] exp_q[$];
  logic        exp_pad_q[$];
  logic [7:0]  exp_sum_q[$];

  // Monitor capture state
  int          cyc = 0;
  int          stray = 0;
  logic [63:0] prev_ops = '0;
  logic [63:0] launch_ops_q[$];
  logic        launch_pad_q[$];
  int          launch_cyc_q[$];
  int          sum_cyc_q[$];

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        if (out_valid) begin
          launch_ops_q.push_back(ops_w);
          launch_pad_q.push_back(pad_flag);
          launch_cyc_q.push_back(cyc);
        end
        if (sum_valid) sum_cyc_q.push_back(cyc);
        if (!out_valid && (ops_w !== prev_ops || pad_flag !== 1'b0)) stray++;
      end
      prev_ops = ops_w;
    end
  end

  // Group-level model: bytes collect until 8 or s_last, then form a group.
  function automatic void mdl_accept(input logic [7:0] d, input logic last);
    logic [63:0] v;
    logic [7:0]  s;
    mdl_bytes.push_back(d);
    if (mdl_bytes.size() == 8 || last) begin
      v = '0;
      s = '0;
      foreach (mdl_bytes[i]) begin
        v[i*8 +: 8] = mdl_bytes[i];
        s = s + mdl_bytes[i];
      end
      exp_q.push_back(v);
      exp_pad_q.push_back(mdl_bytes.size() < 8);
      exp_sum_q.push_back(s);
      mdl_bytes.delete();
    end
  endfunction

  function automatic logic [7:0] byte_sum(input logic [63:0] v);
    logic [7:0] s = '0;
    for (int k = 0; k < 8; k++) s = s + v[k*8 +: 8];
    return s;
  endfunction

  task automatic clear_capture();
    launch_ops_q.delete();
    launch_pad_q.delete();
    launch_cyc_q.delete();
    sum_cyc_q.delete();
    exp_q.delete();
    exp_pad_q.delete();
    exp_sum_q.delete();
    mdl_bytes.delete();
    stray = 0;
  endtask

  // Driver: present one byte and hold it until it transfers (bounded).
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b required 1", s_ready);
    end else begin
      mdl_accept(d, last);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    #1;
    checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL rst_s_ready got %b required 0", s_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL rst_sum_valid got %b required 0", sum_valid); end
    checks++; if (pad_flag !== 1'b0)  begin errors++; $display("FAIL rst_pad_flag got %b required 0", pad_flag); end
    checks++; if (ops_w !== 64'h0)    begin errors++; $display("FAIL rst_ops got %h required 0", ops_w); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready got %b required 0", s_ready); end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_s_ready got %b required 1", s_ready); end
  endtask

  task automatic test_full_group();
    clear_capture();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    idle(2);
    for (int i = 0; i < 8; i++) send_byte(8'hFF, 1'b0);
    idle(8);
    checks++;
    if (launch_ops_q.size() != exp_q.size()) begin errors++; $display("FAIL full_launch_count got %0d required %0d", launch_ops_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launch_ops_q.size(); i++) begin
      checks++; if (launch_ops_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_ops[%0d] got %h required %h", i, launch_ops_q[i], exp_q[i]); end
      checks++; if (launch_pad_q[i] !== exp_pad_q[i]) begin errors++; $display("FAIL full_pad[%0d] got %b required %b", i, launch_pad_q[i], exp_pad_q[i]); end
    end
    checks++;
    if (sum_cyc_q.size() != exp_q.size()) begin errors++; $display("FAIL full_sum_count got %0d required %0d", sum_cyc_q.size(), exp_q.size()); end
    for (int i = 0; i < sum_cyc_q.size() && i < launch_cyc_q.size() && i < exp_sum_q.size(); i++) begin
      checks++; if (sum_cyc_q[i] != launch_cyc_q[i] + 3) begin errors++; $display("FAIL full_latency[%0d] got %0d required %0d", i, sum_cyc_q[i] - launch_cyc_q[i], 3); end
      checks++; if (byte_sum(launch_ops_q[i]) !== exp_sum_q[i]) begin errors++; $display("FAIL full_sum[%0d] got %h required %h", i, byte_sum(launch_ops_q[i]), exp_sum_q[i]); end
    end
    if (launch_ops_q.size() >= 2) begin
      checks++; if (byte_sum(launch_ops_q[0]) !== 8'd36) begin errors++; $display("FAIL full_sum36 got %0d required 36", byte_sum(launch_ops_q[0])); end
      checks++; if (byte_sum(launch_ops_q[1]) !== 8'hF8) begin errors++; $display("FAIL full_sum_wrap got %h required f8", byte_sum(launch_ops_q[1])); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL full_hold got %0d stray changes required 0", stray); end
  endtask

  task automatic test_short_group();
    int len;
    clear_capture();
    send_byte(8'd10, 1'b0);
    send_byte(8'd20, 1'b0);
    send_byte(8'd30, 1'b1);
    idle(3);
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), (i == len - 1));
      idle($urandom_range(1, 2));
    end
    idle(8);
    checks++;
    if (launch_ops_q.size() != exp_q.size()) begin errors++; $display("FAIL short_launch_count got %0d required %0d", launch_ops_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launch_ops_q.size(); i++) begin
      checks++; if (launch_ops_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_ops[%0d] got %h required %h", i, launch_ops_q[i], exp_q[i]); end
      checks++; if (launch_pad_q[i] !== exp_pad_q[i]) begin errors++; $display("FAIL short_pad[%0d] got %b required %b", i, launch_pad_q[i], exp_pad_q[i]); end
    end
    checks++;
    if (sum_cyc_q.size() != exp_q.size()) begin errors++; $display("FAIL short_sum_count got %0d required %0d", sum_cyc_q.size(), exp_q.size()); end
    for (int i = 0; i < sum_cyc_q.size() && i < launch_cyc_q.size() && i < exp_sum_q.size(); i++) begin
      checks++; if (sum_cyc_q[i] != launch_cyc_q[i] + 3) begin errors++; $display("FAIL short_latency[%0d] got %0d required %0d", i, sum_cyc_q[i] - launch_cyc_q[i], 3); end
      checks++; if (byte_sum(launch_ops_q[i]) !== exp_sum_q[i]) begin errors++; $display("FAIL short_sum[%0d] got %h required %h", i, byte_sum(launch_ops_q[i]), exp_sum_q[i]); end
    end
    if (launch_ops_q.size() >= 1) begin
      checks++; if (launch_ops_q[0] !== 64'h0000_0000_001E_140A) begin errors++; $display("FAIL short_ops_fixed got %h required 1e140a", launch_ops_q[0]); end
      checks++; if (launch_pad_q[0] !== 1'b1) begin errors++; $display("FAIL short_pad_fixed got %b required 1", launch_pad_q[0]); end
      checks++; if (byte_sum(launch_ops_q[0]) !== 8'd60) begin errors++; $display("FAIL short_sum60 got %0d required 60", byte_sum(launch_ops_q[0])); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL short_hold got %0d stray changes required 0", stray); end
  endtask

  task automatic test_back_to_back();
    int len;
    clear_capture();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 8; i++) begin
        send_byte(8'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
    end
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), (i == len - 1));
    end
    idle(8);
    checks++;
    if (launch_ops_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_launch_count got %0d required %0d", launch_ops_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launch_ops_q.size(); i++) begin
      checks++; if (launch_ops_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ops[%0d] got %h required %h", i, launch_ops_q[i], exp_q[i]); end
      checks++; if (launch_pad_q[i] !== exp_pad_q[i]) begin errors++; $display("FAIL b2b_pad[%0d] got %b required %b", i, launch_pad_q[i], exp_pad_q[i]); end
    end
    checks++;
    if (sum_cyc_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_sum_count got %0d required %0d", sum_cyc_q.size(), exp_q.size()); end
    for (int i = 0; i < sum_cyc_q.size() && i < launch_cyc_q.size() && i < exp_sum_q.size(); i++) begin
      checks++; if (sum_cyc_q[i] != launch_cyc_q[i] + 3) begin errors++; $display("FAIL b2b_latency[%0d] got %0d required %0d", i, sum_cyc_q[i] - launch_cyc_q[i], 3); end
      checks++; if (byte_sum(launch_ops_q[i]) !== exp_sum_q[i]) begin errors++; $display("FAIL b2b_sum[%0d] got %h required %h", i, byte_sum(launch_ops_q[i]), exp_sum_q[i]); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL b2b_hold got %0d stray changes required 0", stray); end
  endtask

  task automatic test_reset_mid_fill();
    // In-flight cancel: launch a group, then reset before its sum_valid.
    clear_capture();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    mdl_bytes.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(8);
    checks++; if (launch_ops_q.size() != 1) begin errors++; $display("FAIL cancel_launch_count got %0d required 1", launch_ops_q.size()); end
    if (launch_ops_q.size() >= 1 && exp_q.size() >= 1) begin
      checks++; if (launch_ops_q[0] !== exp_q[0]) begin errors++; $display("FAIL cancel_ops got %h required %h", launch_ops_q[0], exp_q[0]); end
    end
    checks++; if (sum_cyc_q.size() != 0) begin errors++; $display("FAIL cancel_sum_count got %0d required 0", sum_cyc_q.size()); end

    // Partial group of 5 discarded by reset, then a clean group.
    clear_capture();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++; if (ops_w !== 64'h0)     begin errors++; $display("FAIL mid_rst_ops got %h required 0", ops_w); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_out_valid got %b required 0", out_valid); end
    checks++; if (sum_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_sum_valid got %b required 0", sum_valid); end
    checks++; if (pad_flag !== 1'b0)   begin errors++; $display("FAIL mid_rst_pad got %b required 0", pad_flag); end
    checks++; if (s_ready !== 1'b0)    begin errors++; $display("FAIL mid_rst_s_ready got %b required 0", s_ready); end
    mdl_bytes.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_idle_s_ready got %b required 0", s_ready); end
    @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_fill_s_ready got %b required 1", s_ready); end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
    idle(8);
    checks++;
    if (launch_ops_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_launch_count got %0d required %0d", launch_ops_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launch_ops_q.size(); i++) begin
      checks++; if (launch_ops_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_ops[%0d] got %h required %h", i, launch_ops_q[i], exp_q[i]); end
      checks++; if (launch_pad_q[i] !== exp_pad_q[i]) begin errors++; $display("FAIL mid_pad[%0d] got %b required %b", i, launch_pad_q[i], exp_pad_q[i]); end
    end
    checks++;
    if (sum_cyc_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_sum_count got %0d required %0d", sum_cyc_q.size(), exp_q.size()); end
    for (int i = 0; i < sum_cyc_q.size() && i < launch_cyc_q.size() && i < exp_sum_q.size(); i++) begin
      checks++; if (sum_cyc_q[i] != launch_cyc_q[i] + 3) begin errors++; $display("FAIL mid_latency[%0d] got %0d required %0d", i, sum_cyc_q[i] - launch_cyc_q[i], 3); end
      checks++; if (byte_sum(launch_ops_q[i]) !== exp_sum_q[i]) begin errors++; $display("FAIL mid_sum[%0d] got %h required %h", i, byte_sum(launch_ops_q[i]), exp_sum_q[i]); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_hold got %0d stray changes required 0", stray); end
  endtask

`ifdef ADDER_LOADER_FLUSH_EN
  task automatic test_flush();
    clear_capture();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    flush = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h63;
    s_last = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    s_valid = 1'b0;
    mdl_bytes.delete();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h55;
    @(negedge clk);
    flush = 1'b0;
    s_valid = 1'b0;
    mdl_bytes.delete();
    #1;
    checks++; if (ops_w !== 64'h0807_0605_0403_0201) begin errors++; $display("FAIL flush_hold_ops got %h required 0807060504030201", ops_w); end
    checks++; if (launch_ops_q.size() != 1) begin errors++; $display("FAIL flush_no_launch got %0d launches required 1", launch_ops_q.size()); end
    for (int i = 8; i >= 1; i--) send_byte(8'(i), 1'b0);
    idle(8);
    checks++;
    if (launch_ops_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_launch_count got %0d required %0d", launch_ops_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launch_ops_q.size(); i++) begin
      checks++; if (launch_ops_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_ops[%0d] got %h required %h", i, launch_ops_q[i], exp_q[i]); end
    end
    checks++;
    if (sum_cyc_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_sum_count got %0d required %0d", sum_cyc_q.size(), exp_q.size()); end
    for (int i = 0; i < sum_cyc_q.size() && i < launch_cyc_q.size() && i < exp_sum_q.size(); i++) begin
      checks++; if (sum_cyc_q[i] != launch_cyc_q[i] + 3) begin errors++; $display("FAIL flush_latency[%0d] got %0d required %0d", i, sum_cyc_q[i] - launch_cyc_q[i], 3); end
      checks++; if (byte_sum(launch_ops_q[i]) !== 8'd36) begin errors++; $display("FAIL flush_sum[%0d] got %0d required 36", i, byte_sum(launch_ops_q[i])); end
    end
    if (launch_ops_q.size() >= 2) begin
      checks++; if (launch_ops_q[1] !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL flush_next_group got %h required 0102030405060708", launch_ops_q[1]); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL flush_hold got %0d stray changes required 0", stray); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_group();
    test_short_group();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef ADDER_LOADER_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
